// File: rtl/sap2_mem_pkg.sv
// sap2_mem_pkg: shared types and constants for the SAP-2 external SRAM bridge.
//   mem_state_t : transaction sequencer states
//   PAD_IDLE    : value driven on the pad bus outside the address/data phases
//   ADDR_W/DATA_W : core address and data widths
//   hi_needed() : decides whether the address-high latch must be refreshed
package sap2_mem_pkg;

    localparam int ADDR_W = 16;
    localparam int DATA_W = 8;

    localparam logic [DATA_W-1:0] PAD_IDLE = 8'h00;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ADDR_LO = 3'd1,
        ADDR_HI = 3'd2,
        ACCESS  = 3'd3,
        DONE    = 3'd4
    } mem_state_t;

    // The external high-byte latch keeps its value between accesses, so the
    // ADDR_HI phase is only needed when the latch is unknown or stale.
    function automatic logic hi_needed(input logic valid, input logic [7:0] last,
                                       input logic [7:0] hi);
        return (!valid) || (last != hi);
    endfunction

endpackage

// File: rtl/sap2_wait_counter.sv
// sap2_wait_counter: loadable 3-bit down-counter timing the ACCESS phase.
//   CLK, RST : clock and synchronous active-high reset
//   load     : load load_val (takes priority over dec)
//   load_val : value loaded, the number of extra strobe cycles
//   dec      : decrement by one, saturating at zero
//   zero     : count is zero (final ACCESS cycle)
module sap2_wait_counter (
    input  logic       CLK,
    input  logic       RST,
    input  logic       load,
    input  logic [2:0] load_val,
    input  logic       dec,
    output logic       zero
);

    logic [2:0] count_r;

    // Counter register: load, decrement or hold.
    always_ff @(posedge CLK) begin
        if (RST) begin
            count_r <= 3'd0;
        end else if (load) begin
            count_r <= load_val;
        end else if (dec && (count_r != 3'd0)) begin
            count_r <= count_r - 3'd1;
        end else begin
            count_r <= count_r;
        end
    end

    assign zero = (count_r == 3'd0);

endmodule

// File: rtl/sap2_mem_bridge.sv
// sap2_mem_bridge: sequences a single-cycle SAP-2 memory request onto a
// multiplexed 8-bit SRAM pad bus (ALE low, optional ALE high, strobed data).
//   CLK, RST                      : clock, synchronous active-high reset
//   mem_req/mem_we/mem_addr/mem_wdata : core request, sampled while idle
//   mem_rdata/mem_ready/mem_busy  : core response and busy flag
//   pad_out/pad_oe/pad_in         : shared pad bus
//   ale_lo/ale_hi                 : external address latch strobes
//   we_n/oe_n                     : active-low SRAM write strobe / output enable
// All outputs are registers loaded from the decode of the next state.
module sap2_mem_bridge
    import sap2_mem_pkg::*;
#(
    parameter int WAIT_CYCLES = 1
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              mem_req,
    input  logic              mem_we,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,
    output logic [DATA_W-1:0] mem_rdata,
    output logic              mem_ready,
    output logic              mem_busy,
    output logic [DATA_W-1:0] pad_out,
    output logic              pad_oe,
    input  logic [DATA_W-1:0] pad_in,
    output logic              ale_lo,
    output logic              ale_hi,
    output logic              we_n,
    output logic              oe_n
);

    localparam logic [2:0] WAIT_LOAD = 3'(WAIT_CYCLES);

    mem_state_t        state_r, next_s;
    logic [ADDR_W-1:0] addr_r, addr_src_s;
    logic              we_r;
    logic [DATA_W-1:0] wdata_r, rdata_r;
    logic              hi_valid_r;
    logic [7:0]        hi_last_r;
    logic              cnt_load_s, cnt_dec_s, cnt_zero_s;

    logic [DATA_W-1:0] pad_out_s, pad_out_r;
    logic              pad_oe_s, pad_oe_r;
    logic              ale_lo_s, ale_lo_r, ale_hi_s, ale_hi_r;
    logic              we_n_s, we_n_r, oe_n_s, oe_n_r;
    logic              ready_r, busy_r;

    sap2_wait_counter u_wait (
        .CLK      (CLK),
        .RST      (RST),
        .load     (cnt_load_s),
        .load_val (WAIT_LOAD),
        .dec      (cnt_dec_s),
        .zero     (cnt_zero_s)
    );

    // The ADDR_LO outputs are computed in the accepting cycle, before the
    // request has been captured, so the address comes straight from the core.
    assign addr_src_s = (state_r == IDLE) ? mem_addr : addr_r;

    // Next-state logic and wait-counter control.
    always_comb begin
        next_s     = state_r;
        cnt_load_s = 1'b0;
        cnt_dec_s  = 1'b0;
        case (state_r)
            IDLE: begin
                if (mem_req) next_s = ADDR_LO;
                else         next_s = IDLE;
            end
            ADDR_LO: begin
                if (hi_needed(hi_valid_r, hi_last_r, addr_r[15:8])) begin
                    next_s = ADDR_HI;
                end else begin
                    next_s     = ACCESS;
                    cnt_load_s = 1'b1;
                end
            end
            ADDR_HI: begin
                next_s     = ACCESS;
                cnt_load_s = 1'b1;
            end
            ACCESS: begin
                if (cnt_zero_s) next_s = DONE;
                else            cnt_dec_s = 1'b1;
            end
            DONE:    next_s = IDLE;
            default: next_s = IDLE;
        endcase
    end

    // Pad and strobe values for the state being entered.
    always_comb begin
        pad_out_s = PAD_IDLE;
        pad_oe_s  = 1'b0;
        ale_lo_s  = 1'b0;
        ale_hi_s  = 1'b0;
        we_n_s    = 1'b1;
        oe_n_s    = 1'b1;
        case (next_s)
            ADDR_LO: begin
                pad_out_s = addr_src_s[7:0];
                pad_oe_s  = 1'b1;
                ale_lo_s  = 1'b1;
            end
            ADDR_HI: begin
                pad_out_s = addr_r[15:8];
                pad_oe_s  = 1'b1;
                ale_hi_s  = 1'b1;
            end
            ACCESS: begin
                if (we_r) begin
                    pad_out_s = wdata_r;
                    pad_oe_s  = 1'b1;
                    we_n_s    = 1'b0;
                end else begin
                    oe_n_s    = 1'b0;
                end
            end
            default: begin
                pad_out_s = PAD_IDLE;
            end
        endcase
    end

    // State, request capture, high-byte tracking, read data and output registers.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_r    <= IDLE;
            addr_r     <= 16'h0000;
            we_r       <= 1'b0;
            wdata_r    <= 8'h00;
            hi_valid_r <= 1'b0;
            hi_last_r  <= 8'h00;
            rdata_r    <= 8'h00;
            pad_out_r  <= PAD_IDLE;
            pad_oe_r   <= 1'b0;
            ale_lo_r   <= 1'b0;
            ale_hi_r   <= 1'b0;
            we_n_r     <= 1'b1;
            oe_n_r     <= 1'b1;
            ready_r    <= 1'b0;
            busy_r     <= 1'b0;
        end else begin
            state_r <= next_s;
            if ((state_r == IDLE) && mem_req) begin
                addr_r  <= mem_addr;
                we_r    <= mem_we;
                wdata_r <= mem_wdata;
            end
            if (state_r == ADDR_HI) begin
                hi_last_r  <= addr_r[15:8];
                hi_valid_r <= 1'b1;
            end
            if ((state_r == ACCESS) && !we_r && cnt_zero_s) begin
                rdata_r <= pad_in;
            end
            pad_out_r <= pad_out_s;
            pad_oe_r  <= pad_oe_s;
            ale_lo_r  <= ale_lo_s;
            ale_hi_r  <= ale_hi_s;
            we_n_r    <= we_n_s;
            oe_n_r    <= oe_n_s;
            ready_r   <= (next_s == DONE);
            busy_r    <= (next_s != IDLE);
        end
    end

    assign mem_rdata = rdata_r;
    assign mem_ready = ready_r;
    assign mem_busy  = busy_r;
    assign pad_out   = pad_out_r;
    assign pad_oe    = pad_oe_r;
    assign ale_lo    = ale_lo_r;
    assign ale_hi    = ale_hi_r;
    assign we_n      = we_n_r;
    assign oe_n      = oe_n_r;

endmodule
